// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_data, rt_data,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results staged at issue, committed after latency.
// Define MDU_MADD_EN to decode the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave md_io
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMadd  = 4'd7,
    OpMaddu = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } md_op_e;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            wr_q;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     arch_hi_q, arch_lo_q;

  // Decoded issue attributes
  logic op_signed, op_long, op_div, op_mthi, op_mtlo;
`ifdef MDU_MADD_EN
  logic op_acc, op_sub;
`endif

  always_comb begin
    op_signed = 1'b0;
    op_long   = 1'b0;
    op_div    = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
`ifdef MDU_MADD_EN
    op_acc    = 1'b0;
    op_sub    = 1'b0;
`endif
    unique case (md_io.md_op)
      OpMult:  begin op_long = 1'b1; op_signed = 1'b1; end
      OpMultu: begin op_long = 1'b1; end
      OpDiv:   begin op_long = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
      OpDivu:  begin op_long = 1'b1; op_div = 1'b1; end
      OpMthi:  op_mthi = 1'b1;
      OpMtlo:  op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd:  begin op_long = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      OpMaddu: begin op_long = 1'b1; op_acc = 1'b1; end
      OpMsub:  begin op_long = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      OpMsubu: begin op_long = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Datapath: product, sign-magnitude divide, and final 64-bit result
  logic [31:0] a, b;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_abs, b_abs, b_div, q_abs, r_abs, quo, rem;
  logic [63:0] res;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
`endif

  always_comb begin
    a        = md_io.rs_data;
    b        = md_io.rt_data;
    a_ext    = op_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext    = op_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod     = a_ext * b_ext;

    a_neg    = op_signed & a[31];
    b_neg    = op_signed & b[31];
    a_abs    = a_neg ? (32'd0 - a) : a;
    b_abs    = b_neg ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    // Divisor forced nonzero to keep the divider well-defined; result is dropped anyway
    b_div    = div_zero ? 32'd1 : b_abs;
    q_abs    = a_abs / b_div;
    r_abs    = a_abs % b_div;
    quo      = (a_neg ^ b_neg) ? (32'd0 - q_abs) : q_abs;
    rem      = a_neg ? (32'd0 - r_abs) : r_abs;

    res = prod;
`ifdef MDU_MADD_EN
    acc = {arch_hi_q, arch_lo_q};
    if (op_acc) begin
      res = op_sub ? (acc - prod) : (acc + prod);
    end
`endif
    if (op_div) begin
      res = {rem, quo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      arch_hi_q <= '0;
      arch_lo_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_io.start) begin
            if (op_mthi) arch_hi_q <= md_io.rs_data;
            if (op_mtlo) arch_lo_q <= md_io.rs_data;
            if (op_long) begin
              hi_q    <= res[63:32];
              lo_q    <= res[31:0];
              wr_q    <= !(op_div && div_zero);
              cnt_q   <= op_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          // Any start seen here is ignored; hazard logic should never allow it
          if (cnt_q == CntW'(1)) begin
            if (wr_q) begin
              arch_hi_q <= hi_q;
              arch_lo_q <= lo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign md_io.busy = busy_q;
  assign md_io.hi   = arch_hi_q;
  assign md_io.lo   = arch_lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; expected values are hand-computed constants.
module tb_md_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [31:0] m_hi, m_lo;

  md_unit_if md_if ();

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .md_io(md_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one start cycle; returns at the falling edge after the start edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.start   = 1'b1;
    md_if.md_op   = op;
    md_if.rs_data = a;
    md_if.rt_data = b;
    @(negedge clk);
    md_if.start   = 1'b0;
    md_if.md_op   = 4'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (md_if.busy && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    issue(op, a, b);
    check({tag, "_hold_hi"}, md_if.hi, m_hi);
    check({tag, "_hold_lo"}, md_if.lo, m_lo);
    wait_idle(cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    m_hi = exp_hi;
    m_lo = exp_lo;
    check({tag, "_hi"}, md_if.hi, m_hi);
    check({tag, "_lo"}, md_if.lo, m_lo);
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    md_if.start   = 1'b0;
    md_if.md_op   = 4'd0;
    md_if.rs_data = '0;
    md_if.rt_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("rst_busy", {31'd0, md_if.busy}, 32'd0);
    check("rst_hi", md_if.hi, 32'd0);
    check("rst_lo", md_if.lo, 32'd0);

    run_long("mult",  4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_long("multu", 4'd2, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_long("div",   4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(4'd5, 32'h0000_0011, 32'd0);
    check("mthi_busy", {31'd0, md_if.busy}, 32'd0);
    check("mthi_hi", md_if.hi, 32'h0000_0011);
    issue(4'd6, 32'h0000_0022, 32'd0);
    check("mtlo_busy", {31'd0, md_if.busy}, 32'd0);
    check("mtlo_lo", md_if.lo, 32'h0000_0022);
    m_hi = 32'h11;
    m_lo = 32'h22;

    run_long("divu0", 4'd4, 32'd7, 32'd0, 10, 32'h0000_0011, 32'h0000_0022);
    run_long("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    // Second start while busy must be ignored
    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    issue(4'd1, 32'd2, 32'd3);
    wait_idle(cyc);
    check("ign_cycles", 32'(cyc + 3), 32'd10);
    check("ign_hi", md_if.hi, 32'd2);
    check("ign_lo", md_if.lo, 32'd14);

    // NONE and undefined ops are ignored
    issue(4'd0, 32'h1234_5678, 32'd1);
    check("none_busy", {31'd0, md_if.busy}, 32'd0);
    issue(4'd15, 32'h1234_5678, 32'd1);
    check("undef_busy", {31'd0, md_if.busy}, 32'd0);
    check("undef_hi", md_if.hi, 32'd2);
    check("undef_lo", md_if.lo, 32'd14);

`ifdef MDU_MADD_EN
    issue(4'd5, 32'h0000_0000, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    m_hi = 32'h0;
    m_lo = 32'hFFFF_FFFF;
    run_long("madd", 4'd7, 32'd2, 32'd3, 5, 32'h0000_0001, 32'h0000_0005);
`else
    issue(4'd7, 32'd2, 32'd3);
    check("madd_off_busy", {31'd0, md_if.busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("madd_off_hi", md_if.hi, 32'd2);
    check("madd_off_lo", md_if.lo, 32'd14);
`endif

    // Reset mid-flight discards the pending result
    issue(4'd1, 32'd5, 32'd5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, md_if.busy}, 32'd0);
    check("abort_hi", md_if.hi, 32'd0);
    check("abort_lo", md_if.lo, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_late_busy", {31'd0, md_if.busy}, 32'd0);
    check("abort_late_lo", md_if.lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide engine sitting beside the single-cycle ALU in the EX stage of the P6 pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX, holds the HI/LO architectural registers, and reports `busy` so hazard logic can stall MFHI/MFLO and later MD requests. Results are computed from operands captured at issue. They are committed to HI/LO only after a fixed latency, modelling a real iterative unit.

## Interface
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (and MADD family).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe, qualified with `md_op`. Sampled once per cycle.
- `md_op`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others are treated as NONE.
- `rs_data`  in  32  operand A (forwarded rs).
- `rt_data`  in  32  operand B (forwarded rt).
- `busy`  out  1  operation in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN.
  - IDLE --start & long op--> RUN. The counter is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
  - In RUN, the counter decrements each cycle.
  - RUN --counter==1--> IDLE. The staged result commits to HI/LO on that same edge.
- Issue captures the full 64-bit result into staging registers `hi_q`/`lo_q` at the start edge:
  - MULT: signed 32x32->64 multiply. HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: unsigned 32x32->64 multiply, same HI/LO split.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient in LO and remainder in HI.
  - MADD family: {HI,LO} ± product, signed or unsigned per op, computed modulo 2^64.
- Divide by zero (`rt_data`==0): the unit still goes busy for `DIV_CYCLES`. HI/LO are left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
- MTHI/MTLO: write `rs_data` to HI/LO at the start edge. `busy` is not asserted.
- `start` while `busy`=1 is ignored: no state change, staging untouched. Hazard logic must prevent this; the bench checks it anyway.
- `start` with op NONE/undefined: ignored.
- MTHI/MTLO issued in the same cycle the commit edge occurs is impossible (commit edge has busy=1), so no write conflict exists.
- `reset`: HI=0, LO=0, staging=0, counter=0, state IDLE, busy=0. Takes effect at the next edge regardless of state; an in-flight result is discarded.

## Timing
- Start edge = edge E0 where `start`=1 is sampled.
- `busy` is registered: it is 1 from just after E0 through the edge E(N), where N = op latency. It is 0 after E(N).
- HI/LO change exactly at E(N). Before E(N), `hi`/`lo` show the old values.
- MTHI/MTLO: `hi`/`lo` show the new value after E0. No busy cycle.
- Back-to-back: a new `start` is accepted on the first edge where `busy`=0, i.e. E(N+1) at the earliest.
- Outputs are register-driven only. There is no combinational path from `start` to `busy`. Stall logic uses `start | busy`.

## Configuration
- `MDU_MADD_EN`: when defined, ops 7-10 are decoded as accumulate ops with `MULT_CYCLES` latency.
- When undefined, ops 7-10 are treated as NONE (ignored, no busy), and the accumulator adder is not synthesized.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 with HI=0x11, LO=0x22 preset via MTHI/MTLO -> busy 10 cycles; HI=0x11, LO=0x22 retained. Each MTHI/MTLO is visible the cycle after issue with busy=0.
- DIV 100/7 issued, then a second `start` MULT 2×3 at cycle 3 -> the second start is ignored; after the commit edge LO=14, HI=2.
- MULT 5×5 issued, `reset` asserted at cycle 2 -> busy=0, HI=LO=0 after the reset edge; no later commit.
  - With `MDU_MADD_EN`: MADD 2×3 starting from HI=0, LO=0xFFFFFFFF -> HI=1, LO=5.
